// File: rtl/dsp_config_chain_loader.sv
// Serializes parallel configuration words into a DSP tile's configuration chain, LSB-first.
// Optional chain readback capture is compiled in when CONFIG_READBACK_EN is defined.
module dsp_config_chain_loader #(
    parameter int CHAIN_LENGTH = 64,
    parameter int WORD_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] cfg_word,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    output logic                  configuration_output,
    output logic                  configuration_enable,
    output logic                  busy,
    output logic                  done
`ifdef CONFIG_READBACK_EN
    ,
    input  logic                  chain_return,
    output logic [WORD_WIDTH-1:0] readback_word,
    output logic                  readback_valid
`endif
);

    localparam int WORDS     = (CHAIN_LENGTH + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int LAST_BITS = CHAIN_LENGTH - (WORDS - 1) * WORD_WIDTH;
    localparam int WL_W      = $clog2(WORDS + 1);
    localparam int BL_W      = $clog2(CHAIN_LENGTH + 1);
    localparam int SC_W      = $clog2(WORD_WIDTH + 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                state;
    logic [WL_W-1:0]       words_left;
    logic [BL_W-1:0]       bits_left;
    logic [WORD_WIDTH-1:0] hold_reg, shreg;
    logic [SC_W-1:0]       hold_cnt, sh_cnt;
    logic                  hold_full;

    logic                  accept;
    logic [SC_W-1:0]       in_cnt;
    logic                  emit, emit_bit, take;
    logic [WORD_WIDTH-1:0] sh_nxt, hold_nxt;
    logic [SC_W-1:0]       sh_cnt_nxt, hold_cnt_nxt;
    logic                  hold_full_nxt;

    // NOTE: cfg_ready is combinational from registered state only, so it cannot loop back through cfg_valid.
    assign cfg_ready = (state == ACTIVE) && !hold_full && (words_left != '0);
    assign accept    = cfg_valid && cfg_ready;
    // The last word carries only the remaining chain bits; its upper bits are never shifted.
    assign in_cnt    = (words_left == WL_W'(1)) ? SC_W'(LAST_BITS) : SC_W'(WORD_WIDTH);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        emit          = 1'b0;
        emit_bit      = 1'b0;
        take          = accept;
        sh_nxt        = shreg;
        sh_cnt_nxt    = sh_cnt;
        hold_nxt      = hold_reg;
        hold_cnt_nxt  = hold_cnt;
        hold_full_nxt = hold_full;
        if (sh_cnt != '0) begin
            emit       = 1'b1;
            emit_bit   = shreg[0];
            sh_nxt     = shreg >> 1;
            sh_cnt_nxt = sh_cnt - 1'b1;
        end else if (hold_full) begin
            emit          = 1'b1;
            emit_bit      = hold_reg[0];
            sh_nxt        = hold_reg >> 1;
            sh_cnt_nxt    = hold_cnt - 1'b1;
            hold_full_nxt = 1'b0;
        end else if (accept) begin
            // Both registers empty: the arriving word starts shifting on this very edge.
            emit       = 1'b1;
            emit_bit   = cfg_word[0];
            sh_nxt     = cfg_word >> 1;
            sh_cnt_nxt = in_cnt - 1'b1;
            take       = 1'b0;
        end
        // Refill the shifter on the edge it drains so the next edge has a bit to send.
        if (sh_cnt_nxt == '0) begin
            if (hold_full_nxt) begin
                sh_nxt        = hold_reg;
                sh_cnt_nxt    = hold_cnt;
                hold_full_nxt = 1'b0;
            end else if (take) begin
                sh_nxt     = cfg_word;
                sh_cnt_nxt = in_cnt;
                take       = 1'b0;
            end
        end
        if (take) begin
            hold_nxt      = cfg_word;
            hold_cnt_nxt  = in_cnt;
            hold_full_nxt = 1'b1;
        end
    end

    // NOTE: hold_reg/shreg data is not reset; the valid counts and hold_full flag mark them empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            state                <= IDLE;
            busy                 <= 1'b0;
            done                 <= 1'b0;
            configuration_output <= 1'b0;
            configuration_enable <= 1'b0;
            words_left           <= '0;
            bits_left            <= '0;
            hold_full            <= 1'b0;
            hold_cnt             <= '0;
            sh_cnt               <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done                 <= 1'b0;
                    configuration_output <= 1'b0;
                    configuration_enable <= 1'b0;
                    if (start) begin
                        state      <= ACTIVE;
                        busy       <= 1'b1;
                        words_left <= WL_W'(WORDS);
                        bits_left  <= BL_W'(CHAIN_LENGTH);
                        hold_full  <= 1'b0;
                        sh_cnt     <= '0;
                    end
                end
                ACTIVE: begin
                    if (bits_left == '0) begin
                        state                <= IDLE;
                        busy                 <= 1'b0;
                        done                 <= 1'b1;
                        configuration_output <= 1'b0;
                        configuration_enable <= 1'b0;
                    end else begin
                        configuration_output <= emit_bit;
                        configuration_enable <= emit;
                        shreg                <= sh_nxt;
                        sh_cnt               <= sh_cnt_nxt;
                        hold_reg             <= hold_nxt;
                        hold_cnt             <= hold_cnt_nxt;
                        hold_full            <= hold_full_nxt;
                        if (accept) words_left <= words_left - 1'b1;
                        if (emit)   bits_left  <= bits_left - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CONFIG_READBACK_EN
    logic [WORD_WIDTH-1:0] rb_acc, rb_next;
    logic [SC_W-1:0]       rb_idx;
    logic [BL_W-1:0]       rb_left;

    assign rb_next = rb_acc | (WORD_WIDTH'(chain_return) << rb_idx);

    // Each shifting cycle, the tail presents one bit of the chain's previous contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            readback_word  <= '0;
            readback_valid <= 1'b0;
            rb_acc         <= '0;
            rb_idx         <= '0;
            rb_left        <= '0;
        end else begin
            readback_valid <= 1'b0;
            if (state == IDLE && start) begin
                rb_acc  <= '0;
                rb_idx  <= '0;
                rb_left <= BL_W'(CHAIN_LENGTH);
            end else if (configuration_enable) begin
                rb_left <= rb_left - 1'b1;
                if (rb_idx == SC_W'(WORD_WIDTH - 1) || rb_left == BL_W'(1)) begin
                    readback_word  <= rb_next;
                    readback_valid <= 1'b1;
                    rb_acc         <= '0;
                    rb_idx         <= '0;
                end else begin
                    rb_acc <= rb_next;
                    rb_idx <= rb_idx + 1'b1;
                end
            end
        end
    end
`endif

endmodule
